// File: rtl/bg_ctrl_if.sv
// Purpose : groups the bandgap trim controller's handshake and analog-control signals.
// Ports   : start/stop/cmp flow into the controller; pwrup, DAC codes, selects,
//           capacitor switches and busy/done flow out. Clock and reset are not carried here.
interface bg_ctrl_if;
  logic       start;
  logic       stop;
  logic       cmp;
  logic       pwrup;
  logic [7:0] idacFine;
  logic [7:0] idacCoarse;
  logic [3:0] idacOutSelect_n;
  logic [7:0] diodeSelect;
  logic       resStableSelect;
  logic       resPtatEnable_n;
  logic [1:0] c1;
  logic [1:0] c2;
  logic       busy;
  logic       done;

  // master: the block that sequences the controller (bench / system logic)
  modport master (
    output start, stop, cmp,
    input  pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, c1, c2, busy, done
  );

  // slave: the controller itself
  modport slave (
    input  start, stop, cmp,
    output pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect,
           resStableSelect, resPtatEnable_n, c1, c2, busy, done
  );
endinterface

// File: rtl/bg_ctrl.sv
// Purpose : bandgap power-up and 8-bit SAR trim of the fine current DAC, with two
//           non-overlapping capacitor phases per bit before each comparator evaluation.
// Latency : outputs registered; full sequence SETTLE_CYCLES + 8*(2*PHASE_CYCLES+3) cycles.
// Backpressure: none; start ignored unless idle, stop aborts to idle from any state.
// Ports   : clk, reset (sync, active-high) plus the bg_ctrl_if slave modport.
module bg_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned PHASE_CYCLES  = 8,
  parameter logic [7:0]  COARSE        = 8'h40
) (
  input  logic      clk,
  input  logic      reset,
  bg_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, PWRUP, PH1, GAP1, PH2, GAP2, EVAL, DONE
  } state_t;

  localparam logic [9:0] SETTLE_LAST = 10'(SETTLE_CYCLES - 1);
  localparam logic [9:0] PHASE_LAST  = 10'(PHASE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] fine_q, fine_d;

  // Output registers; their next values are decoded from the next state so the
  // outputs change on the same edge the state does, without an input-to-output path.
  logic       pwrup_q, pwrup_d;
  logic [7:0] coarse_q, coarse_d;
  logic [3:0] osel_q, osel_d;
  logic [7:0] diode_q, diode_d;
  logic       rs_q, rs_d;
  logic       rptat_n_q, rptat_n_d;
  logic [1:0] c1_q, c1_d;
  logic [1:0] c2_q, c2_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Next-state, counters and SAR register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    fine_d  = fine_q;

    if (bus.stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = 3'd7;
      fine_d  = 8'h00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = PWRUP;
            cnt_d   = '0;
            bit_d   = 3'd7;
            fine_d  = 8'h80;
          end
        end
        PWRUP: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d = PH1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        PH1: begin
          if (cnt_q == PHASE_LAST) begin
            state_d = GAP1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        GAP1: state_d = PH2;
        PH2: begin
          if (cnt_q == PHASE_LAST) begin
            state_d = GAP2;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
        GAP2: state_d = EVAL;
        EVAL: begin
          // Comparator high means the trial code overshoots: drop the trial bit.
          if (bus.cmp) fine_d[bit_q] = 1'b0;
          if (bit_q != 3'd0) begin
            fine_d[bit_q - 3'd1] = 1'b1;
            bit_d                = bit_q - 3'd1;
            state_d              = PH1;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state
  always_comb begin
    pwrup_d   = 1'b0;
    coarse_d  = 8'h00;
    osel_d    = 4'b1111;
    diode_d   = 8'h00;
    rs_d      = 1'b0;
    rptat_n_d = 1'b1;
    c1_d      = 2'b00;
    c2_d      = 2'b00;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_d)
      PWRUP, PH1, GAP1, PH2, GAP2, EVAL: begin
        pwrup_d   = 1'b1;
        coarse_d  = COARSE;
        osel_d    = 4'b1110;
        diode_d   = 8'hFF;
        rs_d      = 1'b1;
        rptat_n_d = 1'b0;
        busy_d    = 1'b1;
        // Phases are separated by GAP states, so the switches always pass through 00.
        if (state_d == PH1) begin
          c1_d = 2'b01;
          c2_d = 2'b10;
        end else if (state_d == PH2) begin
          c1_d = 2'b10;
          c2_d = 2'b01;
        end
      end
      DONE: begin
        pwrup_d   = 1'b1;
        coarse_d  = COARSE;
        osel_d    = 4'b1101;
        diode_d   = 8'hFF;
        rs_d      = 1'b1;
        rptat_n_d = 1'b0;
        done_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd7;
      fine_q    <= 8'h00;
      pwrup_q   <= 1'b0;
      coarse_q  <= 8'h00;
      osel_q    <= 4'b1111;
      diode_q   <= 8'h00;
      rs_q      <= 1'b0;
      rptat_n_q <= 1'b1;
      c1_q      <= 2'b00;
      c2_q      <= 2'b00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      fine_q    <= fine_d;
      pwrup_q   <= pwrup_d;
      coarse_q  <= coarse_d;
      osel_q    <= osel_d;
      diode_q   <= diode_d;
      rs_q      <= rs_d;
      rptat_n_q <= rptat_n_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.pwrup           = pwrup_q;
  assign bus.idacFine        = fine_q;
  assign bus.idacCoarse      = coarse_q;
  assign bus.idacOutSelect_n = osel_q;
  assign bus.diodeSelect     = diode_q;
  assign bus.resStableSelect = rs_q;
  assign bus.resPtatEnable_n = rptat_n_q;
  assign bus.c1              = c1_q;
  assign bus.c2              = c2_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;

endmodule

// File: doc/bg_ctrl.md
BG_CTRL -- requirements
Module: bg_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 64, SHALL set the number of cycles in PWRUP before trimming starts (range 1..1023).
REQ-002 Parameter PHASE_CYCLES, default 8, SHALL set the length in cycles of each capacitor phase (range 1..255).
REQ-003 Parameter COARSE, default 8'h40, SHALL be the idacCoarse code driven while active.
REQ-004 Ports SHALL be:
  clk  input  1  single clock; all logic on rising edge.
  reset  input  1  synchronous, active-high reset.
  start  input  1  pulse; begins a power-up and trim sequence.
  stop  input  1  level; aborts to IDLE.
  cmp  input  1  comparator result; 1 = VP above VN.
  pwrup  output  1  bandgap power-up enable.
  idacFine  output  8  fine current DAC code (SAR register).
  idacCoarse  output  8  coarse current DAC code.
  idacOutSelect_n  output  4  active-low DAC output routing.
  diodeSelect  output  8  diode bank enable.
  resStableSelect  output  1  stable-resistor select.
  resPtatEnable_n  output  1  active-low PTAT resistor enable.
  c1  output  2  capacitor cell 1 switch controls.
  c2  output  2  capacitor cell 2 switch controls.
  busy  output  1  high in PWRUP/PH1/GAP1/PH2/GAP2/EVAL.
  done  output  1  high in DONE.

Function
REQ-005 FSM states SHALL be IDLE, PWRUP, PH1, GAP1, PH2, GAP2, EVAL, DONE.
REQ-006 IDLE: start=1 -> PWRUP next cycle; idacFine loaded with 8'h80, bit index = 7.
REQ-007 PWRUP SHALL last exactly SETTLE_CYCLES cycles, then go to PH1.
REQ-008 PH1 and PH2 SHALL each last exactly PHASE_CYCLES cycles; GAP1, GAP2 and EVAL SHALL each last exactly 1 cycle; order PH1 -> GAP1 -> PH2 -> GAP2 -> EVAL.
REQ-009 c1/c2 SHALL be: PH1 c1=2'b01, c2=2'b10; PH2 c1=2'b10, c2=2'b01; every other state 2'b00.
REQ-010 c1 and c2 SHALL never change from one non-zero value straight to another; a 2'b00 cycle always separates them.
REQ-011 EVAL with bit index i: cmp=1 -> clear idacFine[i]; cmp=0 -> keep it. Then if i>0, set idacFine[i-1], i decrements, next state PH1; if i=0 -> DONE.
REQ-012 A full trim SHALL take 8*(2*PHASE_CYCLES+3) cycles from entry to PH1 until DONE; with defaults that is 152 cycles.
REQ-013 Per state, pwrup / diodeSelect / resStableSelect / resPtatEnable_n / idacCoarse / idacOutSelect_n SHALL be:
  - IDLE: 0 / 8'h00 / 0 / 1 / 8'h00 / 4'b1111.
  - busy states: 1 / 8'hFF / 1 / 0 / COARSE / 4'b1110.
  - DONE: 1 / 8'hFF / 1 / 0 / COARSE / 4'b1101.
REQ-014 DONE SHALL hold idacFine and all outputs constant until stop=1 or reset=1.
REQ-015 start while busy or done SHALL be ignored.
REQ-016 stop=1 in any state SHALL move to IDLE next cycle, clear idacFine to 8'h00 and force c1=c2=2'b00; stop takes priority over start in the same cycle.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-018 reset=1 SHALL put the FSM in IDLE, with pwrup=0, idacFine=8'h00, idacCoarse=8'h00, idacOutSelect_n=4'b1111, diodeSelect=8'h00, resStableSelect=0, resPtatEnable_n=1, c1=c2=2'b00, busy=0 and done=0 on the next edge.
REQ-019 reset SHALL take priority over start and stop; reset mid-sequence SHALL abort with the REQ-018 values.

Verification
REQ-020 Reset with defaults -> all outputs at REQ-018 values; start pulse -> busy=1, pwrup=1, idacFine=8'h80, idacCoarse=8'h40 one cycle later.
REQ-021 cmp held 0 -> done after 64+152 cycles with idacFine=8'hFF and idacOutSelect_n=4'b1101; cmp held 1 -> idacFine=8'h00.
REQ-022 cmp model returning 1 when idacFine > 8'h5A -> final idacFine=8'h5A.
REQ-023 Check every cycle that c1 and c2 never both go non-zero in opposite phases without a 2'b00 gap; check PH1/PH2 widths equal PHASE_CYCLES (bench also run with PHASE_CYCLES=1).
REQ-024 stop asserted in PH2 of bit 3 -> IDLE next cycle with idacFine=8'h00; a new start then re-trims from 8'h80.
REQ-025 reset asserted during EVAL together with start -> REQ-018 values; start pulses during busy and DONE -> no state change.
